booth_mul_seq: RTL
==================

Name: booth_mul_seq

Overview:
- Sequential radix-4 Booth multiplier controller in the paramul datapath; sits directly upstream of the 64-bit Kogge-Stone adder.
- Each RUN cycle it drives one Booth partial product plus the running accumulator into the adder, then registers the adder sum back into the accumulator.
- The adder stays a separate combinational instance: this block owns the operand registers, Booth recoding, iteration counter, valid/ready handshakes and the result register.

Parameters:
- WIDTH, 32, operand width in bits (signed two's complement); must be even; adder width is 2*WIDTH = 64.
- ITER, WIDTH/2 = 16, number of Booth iterations; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  multiplicand, signed.
- in_b  input  WIDTH  multiplier, signed.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  signed product.
- add_a  output  2*WIDTH  to adder A (accumulator).
- add_b  output  2*WIDTH  to adder B (partial product, possibly inverted).
- add_ci  output  1  to adder Ci.
- add_s  input  2*WIDTH  from adder S (A+B+Ci mod 2^64).

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; acc, mcand, mplier, cnt and product cleared to 0.
  - in_ready=1, out_valid=0, add_a=0, add_b=0, add_ci=0.
  - Takes effect immediately, including mid-RUN or in DONE; any operation in flight is discarded with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge:
    - mcand <= sign-extend(in_a) to 64 bits.
    - mplier <= {in_b, 1'b0} (WIDTH+1 bits; appended LSB is b[-1]=0).
    - acc <= 0; cnt <= 0; state <= RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Booth digit from mplier[2:0]:
    - 000 / 111 -> 0.
    - 001 / 010 -> +1.
    - 011 -> +2.
    - 100 -> -2.
    - 101 / 110 -> -1.
  - Magnitude pp: 0, mcand, or mcand<<1 (64-bit, bits shifted out discarded).
  - Adder drive: add_a = acc.
    - Positive digit: add_b = pp, add_ci = 0.
    - Negative digit: add_b = ~pp, add_ci = 1.
    - Zero digit: add_b = 0, add_ci = 0.
  - Each edge:
    - acc <= add_s.
    - mcand <= mcand<<2.
    - mplier <= arithmetic shift right by 2.
    - cnt <= cnt+1.
  - At the edge where cnt==ITER-1: product <= add_s, state <= DONE.
- DONE:
  - out_valid=1; product held stable until out_valid & out_ready.
  - On that edge: out_valid drops, state <= IDLE.
  - A new operand is not accepted in the same cycle; earliest acceptance is the next cycle (in_ready=1 in IDLE).
- Adder drive outside RUN: add_a=acc, add_b=0, add_ci=0, so nets are deterministic.
- Latency: out_valid rises exactly ITER (16) clock edges after the accepting edge.
- Throughput: one product per 18 cycles at best (accept, 16 RUN, DONE/handshake).
- Arithmetic: all accumulation is modulo 2^64, which gives the exact signed product for every WIDTH-bit signed operand pair, including (-2^31)*(-2^31).
- product is only valid while out_valid=1; its value outside that window is unspecified beyond reset=0.

Test Plan:
- Reset, then in_a=3, in_b=5 accepted:
  - in_ready=0 for 16 cycles, out_valid rises 16 edges after acceptance.
  - product=0x0000_0000_0000_000F; add_ci=1 never observed for this pair (digits +1,+1,0...).
- in_a=0xFFFF_FFFF, in_b=0xFFFF_FFFF (-1 * -1) -> product=0x0000_0000_0000_0001.
- Corner products:
  - in_a=in_b=0x8000_0000 -> product=0x4000_0000_0000_0000.
  - in_a=0x7FFF_FFFF, in_b=0x8000_0000 -> product=0xC000_0000_8000_0000.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid: product and out_valid stay constant, in_ready=0.
  - in_valid pulses during RUN/DONE are ignored (no second result).
  - Raise out_ready: out_valid falls next edge, in_ready=1.
- Reset mid-operation:
  - Assert rst_n=0 at RUN cycle 7: out_valid=0, in_ready=1 and product=0 immediately (async).
  - Next accepted pair 6*7 gives 0x2A with no residue from the aborted pair.
- Randomised: 10,000 random signed pairs with random in_valid/out_ready stalls, paired with the real adder instance.
  - Every product matches a 64-bit signed reference model.
  - Latency is always 16 edges from acceptance.

Source files
------------

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - sequential radix-4 Booth multiplier controller feeding an external 2*WIDTH adder
module booth_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic [2*WIDTH-1:0]   add_a,
   output logic [2*WIDTH-1:0]   add_b,
   output logic                 add_ci,
   input  logic [2*WIDTH-1:0]   add_s
);

   localparam int ITER = WIDTH / 2;
   localparam int AW   = 2 * WIDTH;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [AW-1:0]   acc;
   logic [AW-1:0]   mcand;
   logic [WIDTH:0]  mplier;
   logic [CW-1:0]   cnt;
   logic            last_iter;

   logic            dig_neg;
   logic            dig_one;
   logic            dig_two;
   logic [AW-1:0]   pp;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign last_iter = (cnt == CW'(ITER - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = RUN;
         RUN:     if (last_iter) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Booth digit from the current overlapping triplet {b[2i+1], b[2i], b[2i-1]}
   always_comb begin
      dig_neg = mplier[2];
      dig_one = 1'b0;
      dig_two = 1'b0;
      case (mplier[2:0])
         3'b001, 3'b010, 3'b101, 3'b110: dig_one = 1'b1;
         3'b011, 3'b100:                 dig_two = 1'b1;
         default:                        ;
      endcase
   end

   always_comb begin
      pp = '0;
      if (dig_two) begin
         pp = {mcand[AW-2:0], 1'b0};
      end else if (dig_one) begin
         pp = mcand;
      end
   end

   // Subtraction is ~pp + 1, with the +1 carried on the adder's carry-in
   always_comb begin
      add_a  = acc;
      add_b  = '0;
      add_ci = 1'b0;
      if ((state == RUN) && (dig_one || dig_two)) begin
         add_b  = dig_neg ? ~pp : pp;
         add_ci = dig_neg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand  <= {{WIDTH{in_a[WIDTH-1]}}, in_a};
                  mplier <= {in_b, 1'b0};
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               acc    <= add_s;
               mcand  <= mcand << 2;
               mplier <= {{2{mplier[WIDTH]}}, mplier[WIDTH:2]};
               cnt    <= cnt + CW'(1);
               if (last_iter) begin
                  product <= add_s;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
